// File: rtl/paint_pkg.sv
// Shared tile-grid definitions for the paint writer, BFS engine and renderer.
// Tile codes, grid geometry, RAM word/lane layout and the writer state encoding.
package paint_pkg;
   localparam int TILE_SHIFT     = 3;
   localparam int GRID_BITS      = 6;
   localparam int TILE_BITS      = 2 * GRID_BITS;
   localparam int LANE_BITS      = 2;
   localparam int WORD_ADDR_BITS = TILE_BITS - LANE_BITS;
   localparam int DATA_BITS      = 32;
   localparam int CODE_BITS      = 8;
   localparam int PIX_BITS       = 10;
   localparam int MAX_Y_PIX      = 480;

   localparam logic [CODE_BITS-1:0] TILE_EMPTY = 8'd0;
   localparam logic [CODE_BITS-1:0] TILE_START = 8'd1;
   localparam logic [CODE_BITS-1:0] TILE_END   = 8'd2;
   localparam logic [CODE_BITS-1:0] TILE_WALL  = 8'd4;

   localparam logic [WORD_ADDR_BITS-1:0] LAST_WORD = '1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_OLD_RD, ST_OLD_WR, ST_NEW_RD, ST_NEW_WR, ST_CLEAR
   } paint_state_e;

   function automatic logic code_valid(input logic [CODE_BITS-1:0] code);
      return (code == TILE_EMPTY) || (code == TILE_START) ||
             (code == TILE_END) || (code == TILE_WALL);
   endfunction

   // Lane k of a RAM word holds tile (4*word + k) in bits [8k+7:8k].
   function automatic logic [CODE_BITS-1:0] lane_get(input logic [DATA_BITS-1:0] word,
                                                     input logic [LANE_BITS-1:0] lane);
      return word[8*int'(lane) +: CODE_BITS];
   endfunction

   function automatic logic [DATA_BITS-1:0] lane_merge(input logic [DATA_BITS-1:0] word,
                                                       input logic [LANE_BITS-1:0] lane,
                                                       input logic [CODE_BITS-1:0] code);
      logic [DATA_BITS-1:0] r;
      r = word;
      r[8*int'(lane) +: CODE_BITS] = code;
      return r;
   endfunction
endpackage

// File: rtl/paint_tile_writer_addr_map.sv
// Screen pixel to tile address conversion for the 64x64 paint grid.
// Purely combinational; in_range_o flags pixels that land outside the visible grid.
module tile_addr_map
   import paint_pkg::*;
(
   input  logic [PIX_BITS-1:0]  pix_x_i,
   input  logic [PIX_BITS-1:0]  pix_y_i,
   output logic [TILE_BITS-1:0] tile_o,
   output logic                 in_range_o
);
   logic [PIX_BITS-TILE_SHIFT-1:0] tile_x;
   logic [PIX_BITS-TILE_SHIFT-1:0] tile_y;

   assign tile_x = pix_x_i[PIX_BITS-1:TILE_SHIFT];
   assign tile_y = pix_y_i[PIX_BITS-1:TILE_SHIFT];
   assign tile_o = {tile_y[GRID_BITS-1:0], tile_x[GRID_BITS-1:0]};

   // The tile_y guard is implied by the pixel limit but keeps the top bit accounted for.
   assign in_range_o = (tile_x[PIX_BITS-TILE_SHIFT-1:GRID_BITS] == '0) &&
                       (tile_y[PIX_BITS-TILE_SHIFT-1:GRID_BITS] == '0) &&
                       (pix_y_i < PIX_BITS'(MAX_Y_PIX));
endmodule

// File: rtl/paint_tile_writer.sv
// Turns paint requests into byte-lane read-modify-write cycles on the 1024x32 tile RAM,
// keeps a single start/end tile, and sweeps the whole grid to zero on Clear.
module paint_tile_writer
   import paint_pkg::*;
(
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Write,
   input  logic [CODE_BITS-1:0]      WritePixel,
   input  logic [PIX_BITS-1:0]       WriteX,
   input  logic [PIX_BITS-1:0]       WriteY,
   input  logic                      Lock,
   input  logic                      Clear,
   output logic [WORD_ADDR_BITS-1:0] mem_addr,
   output logic                      mem_re,
   output logic                      mem_we,
   output logic [DATA_BITS-1:0]      mem_wdata,
   input  logic [DATA_BITS-1:0]      mem_rdata,
   output logic                      Busy,
   output logic [TILE_BITS:0]        StartPoint,
   output logic [TILE_BITS:0]        EndPoint,
   output paint_state_e              dbg_state_o
);
   paint_state_e              state_q;
   logic                      write_prev_q;
   logic [TILE_BITS-1:0]      tile_q;
   logic [CODE_BITS-1:0]      code_q;
   logic [LANE_BITS-1:0]      old_lane_q;
   logic [WORD_ADDR_BITS-1:0] addr_q;
   logic                      re_q;
   logic                      busy_q;
   logic [TILE_BITS:0]        start_q;
   logic [TILE_BITS:0]        end_q;

   logic [TILE_BITS-1:0]      req_tile;
   logic                      req_in_range;
   logic                      accept;
   logic                      clear_go;
   logic                      need_old;
   logic [TILE_BITS-1:0]      old_tile;
   logic [CODE_BITS-1:0]      new_lane_prev;
   logic                      old_hit;

   tile_addr_map u_map (
      .pix_x_i    (WriteX),
      .pix_y_i    (WriteY),
      .tile_o     (req_tile),
      .in_range_o (req_in_range)
   );

   assign clear_go = Clear && !Lock;
   assign accept   = Write && !write_prev_q && !Lock && !Clear &&
                     code_valid(WritePixel) && req_in_range;

   // A start/end moved to a different tile must first have its old lane erased.
   always_comb begin
      old_tile = start_q[TILE_BITS-1:0];
      need_old = 1'b0;
      if (WritePixel == TILE_START) begin
         old_tile = start_q[TILE_BITS-1:0];
         need_old = start_q[TILE_BITS] && (start_q[TILE_BITS-1:0] != req_tile);
      end else if (WritePixel == TILE_END) begin
         old_tile = end_q[TILE_BITS-1:0];
         need_old = end_q[TILE_BITS] && (end_q[TILE_BITS-1:0] != req_tile);
      end
   end

   assign new_lane_prev = lane_get(mem_rdata, tile_q[LANE_BITS-1:0]);
   assign old_hit       = (lane_get(mem_rdata, old_lane_q) == code_q);

   // Write data depends on the read word that arrives in the write-state cycle itself.
   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state_q)
         ST_OLD_WR: begin
            if (old_hit) begin
               mem_we    = 1'b1;
               mem_wdata = lane_merge(mem_rdata, old_lane_q, TILE_EMPTY);
            end
         end
         ST_NEW_WR: begin
            mem_we    = 1'b1;
            mem_wdata = lane_merge(mem_rdata, tile_q[LANE_BITS-1:0], code_q);
         end
         ST_CLEAR: mem_we = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= ST_IDLE;
         write_prev_q <= 1'b0;
         tile_q       <= '0;
         code_q       <= '0;
         old_lane_q   <= '0;
         addr_q       <= '0;
         re_q         <= 1'b0;
         busy_q       <= 1'b0;
         start_q      <= '0;
         end_q        <= '0;
      end else begin
         write_prev_q <= Write;
         case (state_q)
            ST_IDLE: begin
               if (clear_go) begin
                  state_q           <= ST_CLEAR;
                  busy_q            <= 1'b1;
                  addr_q            <= '0;
                  start_q[TILE_BITS] <= 1'b0;
                  end_q[TILE_BITS]   <= 1'b0;
               end else if (accept) begin
                  tile_q <= req_tile;
                  code_q <= WritePixel;
                  busy_q <= 1'b1;
                  re_q   <= 1'b1;
                  if (need_old) begin
                     state_q    <= ST_OLD_RD;
                     old_lane_q <= old_tile[LANE_BITS-1:0];
                     addr_q     <= old_tile[TILE_BITS-1:LANE_BITS];
                  end else begin
                     state_q <= ST_NEW_RD;
                     addr_q  <= req_tile[TILE_BITS-1:LANE_BITS];
                  end
               end
            end
            ST_OLD_RD: begin
               re_q    <= 1'b0;
               state_q <= ST_OLD_WR;
            end
            ST_OLD_WR: begin
               re_q    <= 1'b1;
               addr_q  <= tile_q[TILE_BITS-1:LANE_BITS];
               state_q <= ST_NEW_RD;
            end
            ST_NEW_RD: begin
               re_q    <= 1'b0;
               state_q <= ST_NEW_WR;
            end
            ST_NEW_WR: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (code_q == TILE_START)
                  start_q <= {1'b1, tile_q};
               else if (new_lane_prev == TILE_START)
                  start_q[TILE_BITS] <= 1'b0;
               if (code_q == TILE_END)
                  end_q <= {1'b1, tile_q};
               else if (new_lane_prev == TILE_END)
                  end_q[TILE_BITS] <= 1'b0;
            end
            ST_CLEAR: begin
               if (addr_q == LAST_WORD) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  addr_q <= addr_q + WORD_ADDR_BITS'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               re_q    <= 1'b0;
            end
         endcase
      end
   end

   assign mem_addr    = addr_q;
   assign mem_re      = re_q;
   assign Busy        = busy_q;
   assign StartPoint  = start_q;
   assign EndPoint    = end_q;
   assign dbg_state_o = state_q;
endmodule

// File: tb/tb_paint_tile_writer.sv
// Bench for paint_tile_writer: RAM model, directed vector table, hand sequences for
// busy/lock/clear corners, and random requests checked against a tile-grid model.
module tb_paint_tile_writer;
   import paint_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        write;
   logic [7:0]  pixel;
   logic [9:0]  wx, wy;
   logic        lock, clr;
   logic [9:0]  mem_addr;
   logic        mem_re, mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] rdata;
   logic        busy;
   logic [12:0] sp, ep;
   paint_state_e dbg_state;

   paint_tile_writer dut (
      .Clk(clk), .Reset(rst), .Write(write), .WritePixel(pixel), .WriteX(wx), .WriteY(wy),
      .Lock(lock), .Clear(clr), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(rdata), .Busy(busy), .StartPoint(sp), .EndPoint(ep),
      .dbg_state_o(dbg_state)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data for a read strobe appears the following cycle.
   logic [31:0] ram [1024];
   logic        ram_wipe;
   always @(posedge clk) begin
      if (ram_wipe) begin
         for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
         rdata <= 32'h0;
      end else begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         if (mem_re) rdata <= ram[mem_addr];
      end
   end

   int both_cnt = 0;
   always @(negedge clk) if (mem_re && mem_we) both_cnt++;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: a flat array of tile codes plus the start/end registers.
   logic [7:0]  g [4096];
   logic [12:0] m_sp, m_ep;

   task automatic model_paint(input int x, input int y, input int code, input bit lk,
                              output bit acc, output bit need_old, output int tile, output int old_tile);
      int prev;
      acc = !lk && (code == 0 || code == 1 || code == 2 || code == 4) && (x / 8 < 64) && (y < 480);
      tile = (y / 8) * 64 + (x / 8);
      old_tile = tile;
      need_old = 1'b0;
      if (!acc) return;
      if (code == 1 && m_sp[12] && int'(m_sp[11:0]) != tile) begin
         need_old = 1'b1; old_tile = int'(m_sp[11:0]);
         if (g[old_tile] == 8'd1) g[old_tile] = 8'd0;
      end
      if (code == 2 && m_ep[12] && int'(m_ep[11:0]) != tile) begin
         need_old = 1'b1; old_tile = int'(m_ep[11:0]);
         if (g[old_tile] == 8'd2) g[old_tile] = 8'd0;
      end
      prev = int'(g[tile]);
      g[tile] = 8'(code);
      if (code == 1) m_sp = {1'b1, 12'(tile)};
      else if (prev == 1) m_sp[12] = 1'b0;
      if (code == 2) m_ep = {1'b1, 12'(tile)};
      else if (prev == 2) m_ep[12] = 1'b0;
   endtask

   function automatic logic [31:0] model_word(input int w);
      return {g[4*w+3], g[4*w+2], g[4*w+1], g[4*w]};
   endfunction

   task automatic check_ram_all(input string name);
      int mism = 0;
      for (int w = 0; w < 1024; w++) if (ram[w] !== model_word(w)) mism++;
      check(name, 64'(mism), 64'(0));
   endtask

   typedef struct {
      logic re; logic we; logic [9:0] addr; logic [31:0] wdata;
   } acc_t;
   acc_t trace_q[$];
   int busy_cycles, idle_acc;

   task automatic run_req(input int x, input int y, input int code, input bit lk,
                          input bit with_clear, input bit lock_mid, input int bound);
      acc_t a;
      trace_q.delete(); busy_cycles = 0; idle_acc = 0;
      @(negedge clk);
      wx = 10'(x); wy = 10'(y); pixel = 8'(code); lock = lk; clr = with_clear; write = 1'b1;
      @(posedge clk);
      @(negedge clk);
      write = 1'b0; clr = 1'b0;
      if (lock_mid) lock = 1'b1;
      for (int c = 0; c < bound; c++) begin
         if (!busy) begin
            if (mem_re || mem_we) idle_acc++;
            break;
         end
         busy_cycles++;
         a.re = mem_re; a.we = mem_we; a.addr = mem_addr; a.wdata = mem_wdata;
         trace_q.push_back(a);
         @(negedge clk);
      end
      lock = 1'b0;
   endtask

   typedef struct {
      string name; int x; int y; int code; bit lk; int cycles;
      logic [9:0] old_addr; logic [31:0] old_wdata;
      logic [9:0] new_addr; logic [31:0] new_wdata;
      logic [12:0] sp; logic [12:0] ep;
   } vec_t;
   vec_t vec_q[$];

   task automatic add_vec(input string n, input int x, input int y, input int code, input bit lk,
                          input int cyc, input logic [9:0] oa, input logic [31:0] ow,
                          input logic [9:0] na, input logic [31:0] nw,
                          input logic [12:0] esp, input logic [12:0] eep);
      vec_t v;
      v.name = n; v.x = x; v.y = y; v.code = code; v.lk = lk; v.cycles = cyc;
      v.old_addr = oa; v.old_wdata = ow; v.new_addr = na; v.new_wdata = nw; v.sp = esp; v.ep = eep;
      vec_q.push_back(v);
   endtask

   int code_tab [9];

   initial begin
      bit acc, need_old;
      int tile, old_tile, k, n, errs, x, y, code;
      bit lk;
      vec_t v;

      code_tab = '{0, 1, 2, 4, 4, 1, 2, 3, 9};
      add_vec("start_60_0",    60,   0, 1, 0, 2, 10'd0, 32'h0,        10'd1,   32'h01000000, 13'h1007, 13'h0000);
      add_vec("end_30_0",      30,   0, 2, 0, 2, 10'd0, 32'h0,        10'd0,   32'h02000000, 13'h1007, 13'h1003);
      add_vec("wall_34_0",     34,   0, 4, 0, 2, 10'd0, 32'h0,        10'd1,   32'h01000004, 13'h1007, 13'h1003);
      add_vec("move_start",   100,   8, 1, 0, 4, 10'd1, 32'h00000004, 10'd19,  32'h00000001, 13'h104C, 13'h1003);
      add_vec("x_oor",        600,   0, 4, 0, 0, 10'd0, 32'h0,        10'd0,   32'h0,        13'h104C, 13'h1003);
      add_vec("bad_code",      40,   0, 3, 0, 0, 10'd0, 32'h0,        10'd0,   32'h0,        13'h104C, 13'h1003);
      add_vec("locked",        40,   0, 4, 1, 0, 10'd0, 32'h0,        10'd0,   32'h0,        13'h104C, 13'h1003);
      add_vec("y_oor",          0, 480, 4, 0, 0, 10'd0, 32'h0,        10'd0,   32'h0,        13'h104C, 13'h1003);
      add_vec("corner",       511, 479, 4, 0, 2, 10'd0, 32'h0,        10'd959, 32'h04000000, 13'h104C, 13'h1003);
      add_vec("wall_on_start",100,   8, 4, 0, 2, 10'd0, 32'h0,        10'd19,  32'h00000004, 13'h004C, 13'h1003);
      add_vec("erase_end",     30,   0, 0, 0, 2, 10'd0, 32'h0,        10'd0,   32'h00000000, 13'h004C, 13'h0003);
      add_vec("restart",       60,   0, 1, 0, 2, 10'd0, 32'h0,        10'd1,   32'h01000004, 13'h1007, 13'h0003);
      add_vec("same_tile",     61,   5, 1, 0, 2, 10'd0, 32'h0,        10'd1,   32'h01000004, 13'h1007, 13'h0003);
      add_vec("end_on_start",  63,   7, 2, 0, 2, 10'd0, 32'h0,        10'd1,   32'h02000004, 13'h0007, 13'h1007);
      add_vec("end_move",     100,   8, 2, 0, 4, 10'd1, 32'h00000004, 10'd19,  32'h00000002, 13'h0007, 13'h104C);

      // Clock/reset
      rst = 1'b1; ram_wipe = 1'b1; write = 1'b0; pixel = '0; wx = '0; wy = '0; lock = 1'b0; clr = 1'b0;
      for (int i = 0; i < 4096; i++) g[i] = 8'd0;
      m_sp = '0; m_ep = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst.busy", 64'(busy), 64'(0));
      check("rst.re_we", 64'({mem_re, mem_we}), 64'(0));
      check("rst.addr_wdata", 64'({mem_addr, mem_wdata}), 64'(0));
      check("rst.points", 64'({sp, ep}), 64'(0));
      check("rst.state", 64'(dbg_state), 64'(ST_IDLE));
      rst = 1'b0; ram_wipe = 1'b0;

      // Directed vector table
      foreach (vec_q[i]) begin
         v = vec_q[i];
         model_paint(v.x, v.y, v.code, v.lk, acc, need_old, tile, old_tile);
         run_req(v.x, v.y, v.code, v.lk, 1'b0, 1'b0, 20);
         check({v.name, ".cycles"}, 64'(busy_cycles), 64'(v.cycles));
         check({v.name, ".idle_acc"}, 64'(idle_acc), 64'(0));
         k = 0;
         if (v.cycles == 4 && trace_q.size() >= 4) begin
            check({v.name, ".old_rd"}, 64'({trace_q[0].re, trace_q[0].we, trace_q[0].addr}),
                  64'({2'b10, v.old_addr}));
            check({v.name, ".old_wr"}, 64'({trace_q[1].re, trace_q[1].we, trace_q[1].addr, trace_q[1].wdata}),
                  64'({2'b01, v.old_addr, v.old_wdata}));
            k = 2;
         end
         if (v.cycles >= 2 && trace_q.size() >= k + 2) begin
            check({v.name, ".new_rd"}, 64'({trace_q[k].re, trace_q[k].we, trace_q[k].addr}),
                  64'({2'b10, v.new_addr}));
            check({v.name, ".new_wr"}, 64'({trace_q[k+1].re, trace_q[k+1].we, trace_q[k+1].addr, trace_q[k+1].wdata}),
                  64'({2'b01, v.new_addr, v.new_wdata}));
         end
         check({v.name, ".start"}, 64'(sp), 64'(v.sp));
         check({v.name, ".end"}, 64'(ep), 64'(v.ep));
      end
      check_ram_all("table.ram");

      // Rising edge landing in NEW_WR must be dropped, and a held level must not re-trigger.
      model_paint(8, 0, 4, 1'b0, acc, need_old, tile, old_tile);
      @(negedge clk); wx = 10'd8; wy = 10'd0; pixel = 8'd4; write = 1'b1;
      @(posedge clk); @(negedge clk); write = 1'b0;
      @(negedge clk); wx = 10'd16; write = 1'b1;
      @(negedge clk);
      check("busy_edge.idle1", 64'(busy), 64'(0));
      @(negedge clk);
      check("busy_edge.idle2", 64'(busy), 64'(0));
      write = 1'b0;
      @(negedge clk);
      check("busy_edge.word0", 64'(ram[0]), 64'(model_word(0)));

      // Lock rising mid-operation lets the current paint finish.
      model_paint(24, 0, 4, 1'b0, acc, need_old, tile, old_tile);
      run_req(24, 0, 4, 1'b0, 1'b0, 1'b1, 20);
      check("lock_mid.cycles", 64'(busy_cycles), 64'(2));
      check("lock_mid.word0", 64'(ram[0]), 64'(model_word(0)));

      // Clear under Lock is ignored.
      run_req(24, 0, 7, 1'b1, 1'b1, 1'b0, 20);
      check("clear_locked.cycles", 64'(busy_cycles), 64'(0));
      check("clear_locked.idle_acc", 64'(idle_acc), 64'(0));

      // Randomized requests against the grid model
      for (int r = 0; r < 150; r++) begin
         x = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 79));
         y = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 39));
         code = code_tab[$urandom_range(0, 8)];
         lk = ($urandom_range(0, 9) == 0);
         model_paint(x, y, code, lk, acc, need_old, tile, old_tile);
         run_req(x, y, code, lk, 1'b0, 1'b0, 20);
         check($sformatf("rnd%0d.cycles", r), 64'(busy_cycles), 64'(acc ? (need_old ? 4 : 2) : 0));
         check($sformatf("rnd%0d.idle_acc", r), 64'(idle_acc), 64'(0));
         check($sformatf("rnd%0d.points", r), 64'({sp, ep}), 64'({m_sp, m_ep}));
         if (acc) begin
            check($sformatf("rnd%0d.word", r), 64'(ram[tile/4]), 64'(model_word(tile/4)));
            if (trace_q.size() > 0)
               check($sformatf("rnd%0d.last_wr", r),
                     64'({trace_q[trace_q.size()-1].we, trace_q[trace_q.size()-1].addr}),
                     64'({1'b1, 10'(tile/4)}));
         end
         if (need_old)
            check($sformatf("rnd%0d.old_word", r), 64'(ram[old_tile/4]), 64'(model_word(old_tile/4)));
      end
      check_ram_all("rnd.ram");

      // Clear with a valid Write edge in the same cycle: Clear wins.
      @(negedge clk); clr = 1'b1; wx = 10'd200; wy = 10'd200; pixel = 8'd4; write = 1'b1;
      @(posedge clk); @(negedge clk); clr = 1'b0; write = 1'b0;
      n = 0; errs = 0;
      for (int c = 0; c < 1100; c++) begin
         if (!busy) break;
         if (!(mem_we && !mem_re && mem_addr == 10'(n) && mem_wdata == 32'h0)) errs++;
         n++;
         @(negedge clk);
      end
      for (int i = 0; i < 4096; i++) g[i] = 8'd0;
      m_sp[12] = 1'b0; m_ep[12] = 1'b0;
      check("clear.cycles", 64'(n), 64'(1024));
      check("clear.seq_errs", 64'(errs), 64'(0));
      check("clear.valid_bits", 64'({sp[12], ep[12]}), 64'(0));
      check_ram_all("clear.ram");

      // Reset during the sweep stops RAM traffic immediately.
      model_paint(60, 0, 1, 1'b0, acc, need_old, tile, old_tile);
      run_req(60, 0, 1, 1'b0, 1'b0, 1'b0, 20);
      model_paint(511, 479, 4, 1'b0, acc, need_old, tile, old_tile);
      run_req(511, 479, 4, 1'b0, 1'b0, 1'b0, 20);
      @(negedge clk); clr = 1'b1;
      @(posedge clk); @(negedge clk); clr = 1'b0;
      n = 0;
      while (!(mem_we && mem_addr == 10'd500) && n < 1100) begin
         n++;
         @(negedge clk);
      end
      check("abort.reached_500", 64'(mem_addr), 64'(500));
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("abort.we", 64'(mem_we), 64'(0));
      check("abort.busy", 64'(busy), 64'(0));
      check("abort.state", 64'(dbg_state), 64'(ST_IDLE));
      rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i <= 2003; i++) g[i] = 8'd0;
      m_sp = '0; m_ep = '0;
      check("abort.points", 64'({sp, ep}), 64'(0));
      check_ram_all("abort.ram");

      model_paint(60, 0, 1, 1'b0, acc, need_old, tile, old_tile);
      run_req(60, 0, 1, 1'b0, 1'b0, 1'b0, 20);
      check("post_reset.cycles", 64'(busy_cycles), 64'(2));
      check("post_reset.start", 64'(sp), 64'(m_sp));
      check("post_reset.word1", 64'(ram[1]), 64'(model_word(1)));

      check("re_we_exclusive", 64'(both_cnt), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
